alu_ctrl_ext: RTL and testbench

ALU_CTRL_EXT -- requirements
Module: alu_ctrl_ext

---
 rtl/alu_ctrl_ext_pkg.sv | 122 ++++++++++++
 rtl/alu_ctrl_ext_decode.sv | 90 +++++++++
 rtl/alu_ctrl_ext.sv | 120 ++++++++++++
 tb/tb_alu_ctrl_ext.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_ext_pkg
// Description : Shared constants for the ALU control / extend block:
//               5-bit ALU opcodes, MIPS opcode/funct values, the operand and
//               writeback select encodings, the packed control word, and
//               helpers that build the common R-type / I-type control words.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_ext_pkg;

  // ALU operation codes. Code 0 is "no operation", so an all-zero control
  // word yields a zero result.
  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_SLL  = 5'd9;
  localparam logic [4:0] ALU_SRL  = 5'd10;
  localparam logic [4:0] ALU_SRA  = 5'd11;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Operand A select
  localparam logic [1:0] SRC_A_RS    = 2'd0;
  localparam logic [1:0] SRC_A_LUI   = 2'd1;
  localparam logic [1:0] SRC_A_SHAMT = 2'd2;
  localparam logic [1:0] SRC_A_ZERO  = 2'd3;

  // Operand B select
  localparam logic [1:0] SRC_B_RT    = 2'd0;
  localparam logic [1:0] SRC_B_IMM   = 2'd1;
  localparam logic [1:0] SRC_B_ZERO  = 2'd2;

  // Destination register select
  localparam logic [1:0] REG_DST_RT  = 2'd0;
  localparam logic [1:0] REG_DST_RD  = 2'd1;
  localparam logic [1:0] REG_DST_RA  = 2'd2;

  // Writeback source select
  localparam logic [1:0] MEM2REG_ALU = 2'd0;
  localparam logic [1:0] MEM2REG_MEM = 2'd1;
  localparam logic [1:0] MEM2REG_PC  = 2'd2;

  // Field order matches the external 16-bit ctrl_out layout (MSB first).
  typedef struct packed {
    logic [4:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] mem2reg;
    logic       reg_wr;
    logic       mem_wr;
    logic       ext;
  } ctrl_t;

  // Register-register ALU op writing rd.
  function automatic ctrl_t rtype_ctrl(input logic [4:0] op, input logic [1:0] sel_a);
    ctrl_t c;
    c         = '0;
    c.alu_op  = op;
    c.src_a   = sel_a;
    c.src_b   = SRC_B_RT;
    c.reg_dst = REG_DST_RD;
    c.reg_wr  = 1'b1;
    return c;
  endfunction

  // Register-immediate ALU op writing rt.
  function automatic ctrl_t itype_ctrl(input logic [4:0] op, input logic sext);
    ctrl_t c;
    c         = '0;
    c.alu_op  = op;
    c.src_a   = SRC_A_RS;
    c.src_b   = SRC_B_IMM;
    c.reg_dst = REG_DST_RT;
    c.reg_wr  = 1'b1;
    c.ext     = sext;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_ext_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_ext_decode (alu_ctrl_decode)
// Description : Purely combinational MIPS instruction decoder producing the
//               16-bit control word for the ALU / extend datapath.
// Ports       : instr - 32-bit instruction word
//               ctrl  - decoded control word (ctrl_t)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
  import alu_ctrl_ext_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];

  always_comb begin
    ctrl = '0;
    // The all-zero word would otherwise decode as sll $0,$0,0; it is treated
    // as a true bubble with no writes.
    if (instr != 32'h0000_0000) begin
      case (w_opcode)
        OP_RTYPE: begin
          case (w_funct)
            FN_ADD, FN_ADDU: ctrl = rtype_ctrl(ALU_ADD,  SRC_A_RS);
            FN_SUB, FN_SUBU: ctrl = rtype_ctrl(ALU_SUB,  SRC_A_RS);
            FN_AND:          ctrl = rtype_ctrl(ALU_AND,  SRC_A_RS);
            FN_OR:           ctrl = rtype_ctrl(ALU_OR,   SRC_A_RS);
            FN_XOR:          ctrl = rtype_ctrl(ALU_XOR,  SRC_A_RS);
            FN_NOR:          ctrl = rtype_ctrl(ALU_NOR,  SRC_A_RS);
            FN_SLT:          ctrl = rtype_ctrl(ALU_SLT,  SRC_A_RS);
            FN_SLTU:         ctrl = rtype_ctrl(ALU_SLTU, SRC_A_RS);
            FN_SLL:          ctrl = rtype_ctrl(ALU_SLL,  SRC_A_SHAMT);
            FN_SRL:          ctrl = rtype_ctrl(ALU_SRL,  SRC_A_SHAMT);
            FN_SRA:          ctrl = rtype_ctrl(ALU_SRA,  SRC_A_SHAMT);
            FN_SLLV:         ctrl = rtype_ctrl(ALU_SLL,  SRC_A_RS);
            FN_SRLV:         ctrl = rtype_ctrl(ALU_SRL,  SRC_A_RS);
            FN_SRAV:         ctrl = rtype_ctrl(ALU_SRA,  SRC_A_RS);
            FN_JR: begin
              // rs + 0 passes the jump target through the ALU.
              ctrl.alu_op = ALU_ADD;
              ctrl.src_b  = SRC_B_ZERO;
            end
            default:         ctrl = '0;
          endcase
        end
        OP_ADDI, OP_ADDIU: ctrl = itype_ctrl(ALU_ADD,  1'b1);
        OP_SLTI:           ctrl = itype_ctrl(ALU_SLT,  1'b1);
        OP_SLTIU:          ctrl = itype_ctrl(ALU_SLTU, 1'b1);
        OP_ANDI:           ctrl = itype_ctrl(ALU_AND,  1'b0);
        OP_ORI:            ctrl = itype_ctrl(ALU_OR,   1'b0);
        OP_XORI:           ctrl = itype_ctrl(ALU_XOR,  1'b0);
        OP_LUI: begin
          // imm << LUI_SHAMT built from the shifter.
          ctrl       = itype_ctrl(ALU_SLL, 1'b0);
          ctrl.src_a = SRC_A_LUI;
        end
        OP_LW: begin
          ctrl         = itype_ctrl(ALU_ADD, 1'b1);
          ctrl.mem2reg = MEM2REG_MEM;
        end
        OP_SW: begin
          ctrl        = itype_ctrl(ALU_ADD, 1'b1);
          ctrl.reg_wr = 1'b0;
          ctrl.mem_wr = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          ctrl.alu_op = ALU_SUB;
          ctrl.src_b  = SRC_B_RT;
          ctrl.ext    = 1'b1;
        end
        OP_J:   ctrl = '0;
        OP_JAL: begin
          ctrl.reg_dst = REG_DST_RA;
          ctrl.mem2reg = MEM2REG_PC;
          ctrl.reg_wr  = 1'b1;
        end
        default: ctrl = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_ext.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_ext
// Description : MIPS control decode + immediate extend + operand muxes + ALU,
//               with every output registered (1-cycle latency, no stalls).
// Ports       : clk, rst (sync, active-high)
//               in_valid, instr, rs_val, rt_val        - inputs
//               out_valid, ctrl_out, alu_out, ext_imm,
//               zero, ovf                              - registered outputs
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_ext
  import alu_ctrl_ext_pkg::*;
#(
  parameter int unsigned LUI_SHAMT = 16
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        out_valid,
  output logic [15:0] ctrl_out,
  output logic [31:0] alu_out,
  output logic [31:0] ext_imm,
  output logic        zero,
  output logic        ovf
);

  ctrl_t       w_ctrl;
  logic [31:0] w_ext_imm;
  logic [31:0] w_op_a;
  logic [31:0] w_op_b;
  logic [31:0] w_sum;
  logic [31:0] w_diff;
  logic [31:0] w_result;
  logic        w_ovf;

  alu_ctrl_decode u_decode (
    .instr (instr),
    .ctrl  (w_ctrl)
  );

  assign w_ext_imm = w_ctrl.ext ? {{16{instr[15]}}, instr[15:0]}
                                : {16'h0000, instr[15:0]};

  always_comb begin
    w_op_a = 32'h0;
    case (w_ctrl.src_a)
      SRC_A_RS:    w_op_a = rs_val;
      SRC_A_LUI:   w_op_a = 32'(LUI_SHAMT);
      SRC_A_SHAMT: w_op_a = {27'h0, instr[10:6]};
      default:     w_op_a = 32'h0;
    endcase
  end

  always_comb begin
    w_op_b = 32'h0;
    case (w_ctrl.src_b)
      SRC_B_RT:  w_op_b = rt_val;
      SRC_B_IMM: w_op_b = w_ext_imm;
      default:   w_op_b = 32'h0;
    endcase
  end

  assign w_sum  = w_op_a + w_op_b;
  assign w_diff = w_op_a - w_op_b;

  always_comb begin
    w_result = 32'h0;
    w_ovf    = 1'b0;
    case (w_ctrl.alu_op)
      ALU_ADD: begin
        w_result = w_sum;
        // Same-sign operands producing a different-sign result.
        w_ovf    = (w_op_a[31] == w_op_b[31]) && (w_sum[31] != w_op_a[31]);
      end
      ALU_SUB: begin
        w_result = w_diff;
        // Opposite-sign operands where the result sign differs from A.
        w_ovf    = (w_op_a[31] != w_op_b[31]) && (w_diff[31] != w_op_a[31]);
      end
      ALU_AND:  w_result = w_op_a & w_op_b;
      ALU_OR:   w_result = w_op_a | w_op_b;
      ALU_XOR:  w_result = w_op_a ^ w_op_b;
      ALU_NOR:  w_result = ~(w_op_a | w_op_b);
      ALU_SLT:  w_result = {31'h0, $signed(w_op_a) < $signed(w_op_b)};
      ALU_SLTU: w_result = {31'h0, w_op_a < w_op_b};
      // Shifts move B by the low five bits of A.
      ALU_SLL:  w_result = w_op_b << w_op_a[4:0];
      ALU_SRL:  w_result = w_op_b >> w_op_a[4:0];
      ALU_SRA:  w_result = $unsigned($signed(w_op_b) >>> w_op_a[4:0]);
      default: begin
        w_result = 32'h0;
        w_ovf    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_out  <= 16'h0;
      alu_out   <= 32'h0;
      ext_imm   <= 32'h0;
      zero      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      ctrl_out  <= w_ctrl;
      alu_out   <= w_result;
      ext_imm   <= w_ext_imm;
      zero      <= (w_result == 32'h0);
      ovf       <= w_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_ext
// Description : Directed self-checking bench for alu_ctrl_ext. Each step
//               drives one instruction, waits one edge and compares every
//               output against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_ext;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        out_valid;
  logic [15:0] ctrl_out;
  logic [31:0] alu_out;
  logic [31:0] ext_imm;
  logic        zero;
  logic        ovf;

  int total;
  int bad;

  alu_ctrl_ext #(.LUI_SHAMT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .instr     (instr),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .out_valid (out_valid),
    .ctrl_out  (ctrl_out),
    .alu_out   (alu_out),
    .ext_imm   (ext_imm),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 time unit past the next.
  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b);
    in_valid = v;
    instr    = i;
    rs_val   = a;
    rt_val   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic v, input logic [15:0] c,
                            input logic [31:0] alu, input logic [31:0] ext,
                            input logic z, input logic o);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, v});
    chk({tag, ".ctrl"},  {16'h0, ctrl_out},  {16'h0, c});
    chk({tag, ".alu"},   alu_out,            alu);
    chk({tag, ".ext"},   ext_imm,            ext);
    chk({tag, ".zero"},  {31'h0, zero},      {31'h0, z});
    chk({tag, ".ovf"},   {31'h0, ovf},       {31'h0, o});
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    instr    = 32'h0;
    rs_val   = 32'h0;
    rt_val   = 32'h0;
    @(posedge clk);
    #1;

    // Reset overrides a valid, nonzero-result input.
    step(1'b1, 32'h2008_0005, 32'h0000_0001, 32'h0);
    expect_all("reset", 1'b0, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b0);

    rst = 1'b0;
    step(1'b1, 32'h2008_0005, 32'h0, 32'h0);                      // addi
    expect_all("addi", 1'b1, 16'h0825, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0);

    step(1'b1, 32'h3C01_1234, 32'hDEAD_BEEF, 32'h0);              // lui
    expect_all("lui", 1'b1, 16'h48A4, 32'h1234_0000, 32'h0000_1234, 1'b0, 1'b0);

    step(1'b1, 32'h0022_1822, 32'h8000_0000, 32'h0000_0001);      // sub ovf
    expect_all("sub", 1'b1, 16'h1204, 32'h7FFF_FFFF, 32'h0000_1822, 1'b0, 1'b1);

    step(1'b1, 32'h0003_1103, 32'h0000_0000, 32'hF000_0000);      // sra by 4
    expect_all("sra", 1'b1, 16'h5B04, 32'hFF00_0000, 32'h0000_1103, 1'b0, 1'b0);

    step(1'b1, 32'h3000_FFFF, 32'hFFFF_FFFF, 32'h0);              // andi
    expect_all("andi", 1'b1, 16'h1824, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0);

    step(1'b1, 32'h2800_FFFF, 32'hFFFF_FFFE, 32'h0);              // slti -2 < -1
    expect_all("slti", 1'b1, 16'h3825, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);

    step(1'b1, 32'h1022_0003, 32'h0000_0007, 32'h0000_0007);      // beq equal
    expect_all("beq", 1'b1, 16'h1001, 32'h0, 32'h0000_0003, 1'b1, 1'b0);

    step(1'b1, 32'h0000_0000, 32'h1111_1111, 32'h2222_2222);      // bubble
    expect_all("nop", 1'b1, 16'h0000, 32'h0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'h0022_1820, 32'h7FFF_FFFF, 32'h0000_0001);      // add ovf
    expect_all("add", 1'b1, 16'h0A04, 32'h8000_0000, 32'h0000_1820, 1'b0, 1'b1);

    step(1'b1, 32'h03E0_0008, 32'h1234_5678, 32'hFFFF_FFFF);      // jr
    expect_all("jr", 1'b1, 16'h0840, 32'h1234_5678, 32'h0000_0008, 1'b0, 1'b0);

    step(1'b1, 32'h8C22_0010, 32'h0000_1000, 32'h0);              // lw
    expect_all("lw", 1'b1, 16'h082D, 32'h0000_1010, 32'h0000_0010, 1'b0, 1'b0);

    step(1'b1, 32'hAC22_FFFC, 32'h0000_1000, 32'h0);              // sw -4
    expect_all("sw", 1'b1, 16'h0823, 32'h0000_0FFC, 32'hFFFF_FFFC, 1'b0, 1'b0);

    step(1'b1, 32'h0C00_0010, 32'h5555_5555, 32'h0);              // jal
    expect_all("jal", 1'b1, 16'h0414, 32'h0, 32'h0000_0010, 1'b1, 1'b0);

    step(1'b0, 32'h0022_1804, 32'h0000_0004, 32'h0000_0001);      // sllv, in_valid low
    expect_all("sllv", 1'b0, 16'h4A04, 32'h0000_0010, 32'h0000_1804, 1'b0, 1'b0);

    step(1'b1, 32'h0022_182B, 32'h0000_0001, 32'hFFFF_FFFF);      // sltu
    expect_all("sltu", 1'b1, 16'h4204, 32'h0000_0001, 32'h0000_182B, 1'b0, 1'b0);

    step(1'b1, 32'hFC00_1234, 32'h0000_0009, 32'h0000_0009);      // unlisted op
    expect_all("badop", 1'b1, 16'h0000, 32'h0, 32'h0000_1234, 1'b1, 1'b0);

    // Mid-stream reset with in_valid high, then release.
    rst = 1'b1;
    step(1'b1, 32'h2008_0005, 32'h0000_0003, 32'h0);
    expect_all("midrst", 1'b0, 16'h0000, 32'h0, 32'h0, 1'b0, 1'b0);

    rst = 1'b0;
    step(1'b1, 32'h0022_1822, 32'h8000_0000, 32'h0000_0001);
    expect_all("resume", 1'b1, 16'h1204, 32'h7FFF_FFFF, 32'h0000_1822, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
